// File: rtl/fft_n4_frame_feeder.sv
`timescale 1ns/1ps
// Buffers a complex sample stream and replays it as gapless, stream-aligned 4-word frames for the N=4 FFT core.
// Trailing partial-frame zero padding is enabled by defining FFT_N4_FEEDER_PAD_EN.
module fft_n4_frame_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_GAP  = 0
) (
  input  logic                         sys_clk_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic signed [DATA_WIDTH-1:0] s_real_i,
  input  logic signed [DATA_WIDTH-1:0] s_imag_i,
  input  logic                         s_last_i,
  output logic                         sof_o,
  output logic signed [DATA_WIDTH-1:0] xn_real_o,
  output logic signed [DATA_WIDTH-1:0] xn_imag_o,
  output logic [1:0]                   word_idx_o,
  output logic                         busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FRAME_C  = CW'(4);
  localparam logic [3:0]    GAP_LOAD = (FRAME_GAP > 0) ? 4'(FRAME_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

  state_t r_state, w_state_nxt;
  logic [1:0] r_burst_idx, w_burst_idx_nxt;
  logic [3:0] r_gap_cnt, w_gap_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_mem_re [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_im [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_ready;

  logic                  w_wr, w_rd, w_pad_nxt;
  logic [DATA_WIDTH-1:0] w_wr_re, w_wr_im;

  logic                  r_sof, r_busy;
  logic [1:0]            r_word_idx;
  logic [DATA_WIDTH-1:0] r_xn_re, r_xn_im;

`ifdef FFT_N4_FEEDER_PAD_EN
  logic       r_pad;
  logic [1:0] r_wr_phase;
  logic [1:0] w_phase_inc;

  // Pad writes only happen while s_ready_o is low, so they never collide with source accepts.
  assign w_wr        = (s_valid_i & r_ready) | (r_pad & (r_count < DEPTH_C));
  assign w_wr_re     = r_pad ? '0 : s_real_i;
  assign w_wr_im     = r_pad ? '0 : s_imag_i;
  assign w_phase_inc = r_wr_phase + 2'd1;
  assign w_pad_nxt   = w_wr ? ((r_pad | s_last_i) & (w_phase_inc != 2'd0)) : r_pad;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pad      <= 1'b0;
      r_wr_phase <= 2'd0;
    end else begin
      r_pad <= w_pad_nxt;
      if (w_wr) r_wr_phase <= w_phase_inc;
    end
  end
`else
  logic w_unused_last;

  assign w_unused_last = s_last_i;
  assign w_wr          = s_valid_i & r_ready;
  assign w_wr_re       = s_real_i;
  assign w_wr_im       = s_imag_i;
  assign w_pad_nxt     = 1'b0;
`endif

  assign w_rd = (r_state == ST_BURST);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (w_wr) begin
      r_mem_re[r_wr_ptr] <= w_wr_re;
      r_mem_im[r_wr_ptr] <= w_wr_im;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < DEPTH_C) & ~w_pad_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_burst_idx_nxt = r_burst_idx;
    w_gap_cnt_nxt   = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_count >= FRAME_C) begin
          w_state_nxt     = ST_BURST;
          w_burst_idx_nxt = 2'd0;
        end
      end
      ST_BURST: begin
        w_burst_idx_nxt = r_burst_idx + 2'd1;
        // Chaining straight into the next burst keeps back-to-back frames at a 4-cycle pitch.
        if (r_burst_idx == 2'd3) begin
          if (FRAME_GAP > 0) begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = GAP_LOAD;
          end else if (w_count_nxt >= FRAME_C) begin
            w_state_nxt = ST_BURST;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else                   w_gap_cnt_nxt = r_gap_cnt - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_burst_idx <= 2'd0;
      r_gap_cnt   <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_idx <= w_burst_idx_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sof      <= 1'b0;
      r_busy     <= 1'b0;
      r_word_idx <= 2'd0;
      r_xn_re    <= '0;
      r_xn_im    <= '0;
    end else if (w_rd) begin
      r_sof      <= (r_burst_idx == 2'd0);
      r_busy     <= 1'b1;
      r_word_idx <= r_burst_idx;
      r_xn_re    <= r_mem_re[r_rd_ptr];
      r_xn_im    <= r_mem_im[r_rd_ptr];
    end else begin
      r_sof      <= 1'b0;
      r_busy     <= 1'b0;
      r_word_idx <= 2'd0;
    end
  end

  assign s_ready_o  = r_ready;
  assign sof_o      = r_sof;
  assign busy_o     = r_busy;
  assign word_idx_o = r_word_idx;
  assign xn_real_o  = r_xn_re;
  assign xn_imag_o  = r_xn_im;

endmodule

// File: tb/tb_fft_n4_frame_feeder.sv
`timescale 1ns/1ps
// Directed bench for fft_n4_frame_feeder: DUT a runs FRAME_GAP=0, DUT b runs FRAME_GAP=3; queues score output order.
module tb_fft_n4_frame_feeder;

`ifdef FFT_N4_FEEDER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_vld = 1'b0, a_last = 1'b0, a_rdy, a_sof, a_busy;
  logic [31:0] a_re = '0, a_im = '0, a_xre, a_xim;
  logic [1:0]  a_idx_o;
  logic        b_vld = 1'b0, b_last = 1'b0, b_rdy, b_sof, b_busy;
  logic [31:0] b_re = '0, b_im = '0, b_xre, b_xim;
  logic [1:0]  b_idx_o;

  fft_n4_frame_feeder #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .FRAME_GAP(0)) u_a (
    .sys_clk_i(clk), .rst_i(rst), .s_valid_i(a_vld), .s_ready_o(a_rdy),
    .s_real_i(a_re), .s_imag_i(a_im), .s_last_i(a_last), .sof_o(a_sof),
    .xn_real_o(a_xre), .xn_imag_o(a_xim), .word_idx_o(a_idx_o), .busy_o(a_busy)
  );

  fft_n4_frame_feeder #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .FRAME_GAP(3)) u_b (
    .sys_clk_i(clk), .rst_i(rst), .s_valid_i(b_vld), .s_ready_o(b_rdy),
    .s_real_i(b_re), .s_imag_i(b_im), .s_last_i(b_last), .sof_o(b_sof),
    .xn_real_o(b_xre), .xn_imag_o(b_xim), .word_idx_o(b_idx_o), .busy_o(b_busy)
  );

  int vecs = 0;
  int fails = 0;
  int cyc = 0;

  logic [63:0] a_q[$];
  logic [63:0] b_q[$];
  int          a_sof_q[$];
  int          b_sof_q[$];
  logic [1:0]  a_exp_idx = 2'd0;
  logic [1:0]  b_exp_idx = 2'd0;
  logic [1:0]  a_phase = 2'd0;
  logic        b_live = 1'b0;
  logic        b_saw_full = 1'b0;
  int          b_out_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) b_live <= 1'b0;
    else     b_live <= 1'b1;
  end

  // Scoreboard for DUT a: accepts are pushed before their edge, bursts popped as they appear.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (rst) begin
      a_q.delete();
      a_exp_idx = 2'd0;
      a_phase   = 2'd0;
    end else begin
      chk("a_sof_outside_burst", 64'(a_sof & ~a_busy), 64'(0));
      if (a_busy) begin
        chk("a_not_empty", 64'(a_q.size() != 0), 64'(1));
        if (a_q.size() != 0) begin
          exp = a_q.pop_front();
          chk("a_data", {a_xre, a_xim}, exp);
        end
        chk("a_word_idx", 64'(a_idx_o), 64'(a_exp_idx));
        chk("a_sof", 64'(a_sof), 64'(a_exp_idx == 2'd0));
        if (a_sof) a_sof_q.push_back(cyc);
        a_exp_idx = a_exp_idx + 2'd1;
      end
      if (a_vld && a_rdy) begin
        a_q.push_back({a_re, a_im});
        a_phase = a_phase + 2'd1;
        if (PAD_EN && a_last) begin
          while (a_phase != 2'd0) begin
            a_q.push_back(64'd0);
            a_phase = a_phase + 2'd1;
          end
        end
      end
    end
  end

  // Scoreboard for DUT b, plus a check of s_ready against the number of samples held.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (rst) begin
      b_q.delete();
      b_exp_idx = 2'd0;
    end else begin
      if (b_busy) begin
        chk("b_not_empty", 64'(b_q.size() != 0), 64'(1));
        if (b_q.size() != 0) begin
          exp = b_q.pop_front();
          chk("b_data", {b_xre, b_xim}, exp);
        end
        chk("b_word_idx", 64'(b_idx_o), 64'(b_exp_idx));
        chk("b_sof", 64'(b_sof), 64'(b_exp_idx == 2'd0));
        if (b_sof) b_sof_q.push_back(cyc);
        b_exp_idx = b_exp_idx + 2'd1;
        b_out_cnt++;
      end
      if (b_live) begin
        chk("b_ready_vs_count", 64'(b_rdy), 64'(b_q.size() < 8));
        if (!b_rdy) b_saw_full = 1'b1;
      end
      if (b_vld && b_rdy) b_q.push_back({b_re, b_im});
    end
  end

  task automatic send_a(input logic [31:0] re, input logic [31:0] im, input logic last);
    logic got;
    got = 1'b0;
    a_vld = 1'b1; a_re = re; a_im = im; a_last = last;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (a_rdy) got = 1'b1;
    end
    chk("a_send_accepted", 64'(got), 64'(1));
    if (got) begin
      @(posedge clk);
      #1;
    end
    a_vld = 1'b0; a_last = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] re, input logic [31:0] im);
    logic got;
    got = 1'b0;
    b_vld = 1'b1; b_re = re; b_im = im;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (b_rdy) got = 1'b1;
    end
    chk("b_send_accepted", 64'(got), 64'(1));
    if (got) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_a_sof();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(posedge clk);
      #1;
      if (a_sof) got = 1'b1;
    end
    chk("a_sof_seen", 64'(got), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    logic sof_gap_ok;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", 64'(a_rdy), 64'(0));
    chk("rst_a_sof", 64'(a_sof), 64'(0));
    chk("rst_a_busy", 64'(a_busy), 64'(0));
    chk("rst_a_idx", 64'(a_idx_o), 64'(0));
    chk("rst_a_xn", {a_xre, a_xim}, 64'(0));
    chk("rst_b_ready", 64'(b_rdy), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_a_ready", 64'(a_rdy), 64'(1));
    chk("rel_b_ready", 64'(b_rdy), 64'(1));

    // Single frame latency: word 0 two edges after the 4th accept
    for (int i = 1; i <= 4; i++) send_a(32'(i), 32'(i), 1'b0);
    @(posedge clk); #1;
    chk("t1_no_sof_c4", 64'(a_sof | a_busy), 64'(0));
    @(posedge clk); #1;
    chk("t1_sof_c5", 64'(a_sof), 64'(1));
    chk("t1_w0", {a_xre, a_xim, 32'(a_idx_o)}, {32'd1, 32'd1, 32'd0});
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t1_word", {a_xre[15:0], a_xim[15:0], 30'd0, a_idx_o}, {16'(i + 1), 16'(i + 1), 32'(i)});
      chk("t1_sof_low", 64'(a_sof), 64'(0));
    end
    @(posedge clk); #1;
    chk("t1_idle_busy", 64'(a_busy), 64'(0));
    chk("t1_hold_xn", {a_xre, a_xim}, {32'd4, 32'd4});

    // 16 back-to-back samples, gapless frames every 4 cycles
    a_sof_q.delete();
    for (int i = 0; i < 16; i++) send_a(32'(100 + i), ~32'(100 + i), 1'b0);
    for (int n = 0; n < 60 && (a_q.size() != 0 || a_busy); n++) begin
      @(posedge clk); #1;
    end
    chk("t2_drained", 64'(a_q.size()), 64'(0));
    chk("t2_frames", 64'(a_sof_q.size()), 64'(4));
    for (int k = 1; k < a_sof_q.size(); k++)
      chk("t2_sof_pitch", 64'(a_sof_q[k] - a_sof_q[k-1]), 64'(4));

    // FRAME_GAP=3 with valid held high: FIFO fills, nothing lost or duplicated
    b_sof_q.delete();
    for (int i = 0; i < 64; i++) send_b(32'(1000 + i), 32'(2000 + i));
    b_vld = 1'b0;
    for (int n = 0; n < 300 && (b_q.size() != 0 || b_busy); n++) begin
      @(posedge clk); #1;
    end
    chk("t3_drained", 64'(b_q.size()), 64'(0));
    chk("t3_out_count", 64'(b_out_cnt), 64'(64));
    chk("t3_ready_dropped", 64'(b_saw_full), 64'(1));
    chk("t3_frames", 64'(b_sof_q.size()), 64'(16));
    sof_gap_ok = 1'b1;
    for (int k = 1; k < b_sof_q.size(); k++)
      if (b_sof_q[k] - b_sof_q[k-1] < 8) sof_gap_ok = 1'b0;
    chk("t3_sof_spacing", 64'(sof_gap_ok), 64'(1));

    // Reset during word 2 of a burst
    for (int i = 0; i < 4; i++) send_a(32'(200 + i), ~32'(200 + i), 1'b0);
    wait_a_sof();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t4_word2", {a_xre, 32'(a_idx_o)}, {32'd202, 32'd2});
    rst = 1'b1;
    #1;
    chk("t4_rst_flags", {61'd0, a_sof, a_busy, a_rdy}, 64'd0);
    chk("t4_rst_idx", 64'(a_idx_o), 64'(0));
    chk("t4_rst_xn", {a_xre, a_xim}, 64'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t4_rel_ready", 64'(a_rdy), 64'(1));
    for (int i = 0; i < 4; i++) send_a(32'(300 + i), ~32'(300 + i), 1'b0);
    wait_a_sof();
    chk("t4_clean_w0", {a_xre, a_xim}, {32'd300, ~32'd300});
    for (int n = 0; n < 20 && a_busy; n++) begin
      @(posedge clk); #1;
    end

    // 6 samples, last on the 6th
    a_sof_q.delete();
    for (int i = 1; i <= 6; i++) send_a(32'(500 + i), ~32'(500 + i), i == 6);
    chk("t5_ready_after_last0", 64'(a_rdy), 64'(!PAD_EN));
    @(posedge clk); #1;
    chk("t5_ready_after_last1", 64'(a_rdy), 64'(!PAD_EN));
    @(posedge clk); #1;
    chk("t5_ready_after_last2", 64'(a_rdy), 64'(1));
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("t5_left_in_fifo", 64'(a_q.size()), PAD_EN ? 64'(0) : 64'(2));
    chk("t5_frames", 64'(a_sof_q.size()), PAD_EN ? 64'(2) : 64'(1));
    chk("t5_busy_idle", 64'(a_busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
